// File: rtl/alu_acc_sequencer.sv
// Sequencer and accumulator stage around a combinational 16-bit ALU.
// It issues one command at a time, captures the result after a settle time, and returns it with status flags.
module alu_acc_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic        cmd_use_acc,
    output logic [3:0]  alu_func,
    output logic [15:0] alu_ar,
    output logic [15:0] alu_br,
    input  logic [31:0] alu_data,
    input  logic        alu_carry,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_carry,
    output logic        res_zero,
    output logic        res_err,
    output logic [31:0] acc
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_func;
    logic [15:0] r_ar;
    logic [15:0] r_br;
    logic [3:0]  r_cnt;
    logic [31:0] r_acc;
    logic [31:0] r_resData;
    logic        r_resCarry;
    logic        r_resZero;
    logic        r_resErr;

    logic        w_accept;
    logic        w_illegal;
    logic        w_capture;
    logic        w_carryOp;
    logic [15:0] w_opA;

    assign w_accept  = (r_state == IDLE) && cmd_valid;
    assign w_illegal = (cmd_op == 4'd0) || (cmd_op > 4'd11) || ((cmd_op == 4'd4) && (cmd_b == 16'd0));
    assign w_capture = (r_state == EXEC) && (r_cnt == 4'd1);
    assign w_carryOp = (r_func == 4'd1) || (r_func == 4'd2) || (r_func == 4'd10) || (r_func == 4'd11);
    assign w_opA     = cmd_use_acc ? r_acc[15:0] : cmd_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The ALU only sees a live function code while a command is executing.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        alu_func  = 4'd0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = w_illegal ? RESP : EXEC;
                end
            end
            EXEC: begin
                alu_func = r_func;
                if (r_cnt == 4'd1) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_func     <= 4'd0;
            r_ar       <= 16'd0;
            r_br       <= 16'd0;
            r_cnt      <= 4'd0;
            r_acc      <= 32'd0;
            r_resData  <= 32'd0;
            r_resCarry <= 1'b0;
            r_resZero  <= 1'b0;
            r_resErr   <= 1'b0;
        end else begin
            if (w_accept && w_illegal) begin
                r_resData  <= r_acc;
                r_resCarry <= 1'b0;
                r_resZero  <= (r_acc == 32'd0);
                r_resErr   <= 1'b1;
            end else if (w_accept) begin
                r_func <= cmd_op;
                r_ar   <= w_opA;
                r_br   <= cmd_b;
                r_cnt  <= SETTLE_LOAD;
            end
            if (r_state == EXEC) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Only arithmetic ops with a meaningful carry/borrow propagate it.
            if (w_capture) begin
                r_acc      <= alu_data;
                r_resData  <= alu_data;
                r_resCarry <= w_carryOp ? alu_carry : 1'b0;
                r_resZero  <= (alu_data == 32'd0);
                r_resErr   <= 1'b0;
            end
        end
    end

    assign alu_ar    = r_ar;
    assign alu_br    = r_br;
    assign res_data  = r_resData;
    assign res_carry = r_resCarry;
    assign res_zero  = r_resZero;
    assign res_err   = r_resErr;
    assign acc       = r_acc;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Bench for alu_acc_sequencer: a behavioural ALU stands in for the real one, and a per-command model predicts
// the accumulator and the result fields, combined with fixed test-plan values and random commands.
module tb_alu_acc_sequencer;

    localparam int SETTLE = 4;

    logic        clk;
    logic        rst;
    logic        cmdValid;
    logic        cmdReady;
    logic [3:0]  cmdOp;
    logic [15:0] cmdA;
    logic [15:0] cmdB;
    logic        cmdUseAcc;
    logic [3:0]  aluFunc;
    logic [15:0] aluAr;
    logic [15:0] aluBr;
    logic [31:0] aluData;
    logic        aluCarry;
    logic        resValid;
    logic        resReady;
    logic [31:0] resData;
    logic        resCarry;
    logic        resZero;
    logic        resErr;
    logic [31:0] accOut;

    int          testCount = 0;
    int          failCount = 0;

    logic [31:0] modelAcc;
    logic [31:0] expData;
    logic        expCarry;
    logic        expZero;
    logic        expErr;

    alu_acc_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_op(cmdOp),
        .cmd_a(cmdA), .cmd_b(cmdB), .cmd_use_acc(cmdUseAcc),
        .alu_func(aluFunc), .alu_ar(aluAr), .alu_br(aluBr),
        .alu_data(aluData), .alu_carry(aluCarry),
        .res_valid(resValid), .res_ready(resReady), .res_data(resData),
        .res_carry(resCarry), .res_zero(resZero), .res_err(resErr), .acc(accOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU, returns {carry, data}. Non-arithmetic ops drive carry high so the sequencer's masking is visible.
    function automatic logic [32:0] refAlu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] wide;
        logic [31:0] prod;
        case (op)
            4'd1:    begin wide = {1'b0, a} + {1'b0, b}; return {wide[16], 16'd0, wide[15:0]}; end
            4'd2:    begin wide = {1'b0, a} - {1'b0, b}; return {wide[16], 16'd0, wide[15:0]}; end
            4'd3:    begin prod = 32'(a) * 32'(b); return {1'b1, prod}; end
            4'd4:    return (b == 16'd0) ? {1'b1, 32'hFFFF_FFFF} : {1'b1, a % b, a / b};
            4'd5:    return {1'b1, 16'd0, a & b};
            4'd6:    return {1'b1, 16'd0, a | b};
            4'd7:    return {1'b1, 16'd0, ~a};
            4'd8:    return {1'b1, 16'd0, a << b[3:0]};
            4'd9:    return {1'b1, 16'd0, a >> b[3:0]};
            4'd10:   return {(a == 16'hFFFF), 16'd0, a + 16'd1};
            4'd11:   return {(a == 16'h0000), 16'd0, a - 16'd1};
            default: return {1'b1, 32'hDEAD_BEEF};
        endcase
    endfunction

    always_comb {aluCarry, aluData} = refAlu(aluFunc, aluAr, aluBr);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag);
        checkOutput({tag, " res_valid"}, 32'(resValid), 32'd1);
        checkOutput({tag, " res_data"},  resData, expData);
        checkOutput({tag, " res_carry"}, 32'(resCarry), 32'(expCarry));
        checkOutput({tag, " res_zero"},  32'(resZero), 32'(expZero));
        checkOutput({tag, " res_err"},   32'(resErr), 32'(expErr));
        checkOutput({tag, " acc"},       accOut, modelAcc);
        checkOutput({tag, " cmd_ready"}, 32'(cmdReady), 32'd0);
        checkOutput({tag, " alu_func"},  32'(aluFunc), 32'd0);
    endtask

    // Issues one command from IDLE, follows it through EXEC/RESP with holdCycles of backpressure, and returns to IDLE.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic useAcc, input int holdCycles);
        logic [15:0] opA;
        logic        illegal;
        logic [32:0] alu;
        opA     = useAcc ? modelAcc[15:0] : a;
        illegal = (op == 4'd0) || (op >= 4'd12) || (op == 4'd4 && b == 16'd0);
        alu     = refAlu(op, opA, b);
        checkOutput("idle cmd_ready", 32'(cmdReady), 32'd1);
        cmdOp     = op;
        cmdA      = a;
        cmdB      = b;
        cmdUseAcc = useAcc;
        cmdValid  = 1'b1;
        resReady  = 1'b0;
        @(posedge clk); #1;
        cmdValid = 1'b0;
        cmdA     = 16'($urandom);
        cmdB     = 16'($urandom);
        if (illegal) begin
            expData  = modelAcc;
            expCarry = 1'b0;
            expZero  = (modelAcc == 32'd0);
            expErr   = 1'b1;
        end else begin
            for (int i = 0; i < SETTLE; i++) begin
                checkOutput("exec res_valid", 32'(resValid), 32'd0);
                checkOutput("exec cmd_ready", 32'(cmdReady), 32'd0);
                checkOutput("exec alu_func", 32'(aluFunc), 32'(op));
                checkOutput("exec alu_ar", 32'(aluAr), 32'(opA));
                checkOutput("exec alu_br", 32'(aluBr), 32'(b));
                @(posedge clk); #1;
            end
            modelAcc = alu[31:0];
            expData  = alu[31:0];
            expCarry = (op == 4'd1 || op == 4'd2 || op == 4'd10 || op == 4'd11) ? alu[32] : 1'b0;
            expZero  = (alu[31:0] == 32'd0);
            expErr   = 1'b0;
        end
        checkResult("resp");
        for (int i = 0; i < holdCycles; i++) begin
            cmdValid = 1'b1;
            cmdOp    = 4'($urandom_range(1, 11));
            @(posedge clk); #1;
            checkResult("hold");
        end
        cmdValid = 1'b1;
        resReady = 1'b1;
        @(posedge clk); #1;
        cmdValid = 1'b0;
        resReady = 1'b0;
        checkOutput("post res_valid", 32'(resValid), 32'd0);
        checkOutput("post cmd_ready", 32'(cmdReady), 32'd1);
        checkOutput("post res_data", resData, expData);
        checkOutput("post acc", accOut, modelAcc);
    endtask

    initial begin
        rst       = 1'b1;
        cmdValid  = 1'b0;
        cmdOp     = 4'd0;
        cmdA      = 16'd0;
        cmdB      = 16'd0;
        cmdUseAcc = 1'b0;
        resReady  = 1'b0;
        modelAcc  = 32'd0;
        expData   = 32'd0;
        expCarry  = 1'b0;
        expZero   = 1'b0;
        expErr    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset acc", accOut, 32'd0);
        checkOutput("reset res_data", resData, 32'd0);
        checkOutput("reset res_valid", 32'(resValid), 32'd0);
        checkOutput("reset flags", {29'd0, resCarry, resZero, resErr}, 32'd0);
        checkOutput("reset alu", {aluFunc, aluAr, aluBr[11:0]}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("reset cmd_ready", 32'(cmdReady), 32'd1);

        // Add with carry wrapping to zero
        applyStimulus(4'd1, 16'hFFFF, 16'h0001, 1'b0, 0);
        checkOutput("add data", resData, 32'h0000_0000);
        checkOutput("add flags", {30'd0, resCarry, resZero}, 32'd3);

        // Full-width multiply, then shift chained off the accumulator
        applyStimulus(4'd3, 16'h1234, 16'h0100, 1'b0, 1);
        checkOutput("mul data", resData, 32'h0012_3400);
        checkOutput("mul carry masked", 32'(resCarry), 32'd0);
        applyStimulus(4'd8, 16'hAAAA, 16'h0004, 1'b1, 0);
        checkOutput("shl data", resData, 32'h0000_4000);
        checkOutput("shl ar", 32'(aluAr), 32'h3400);

        // Divide by zero leaves the accumulator alone
        applyStimulus(4'd1, 16'h0003, 16'h0004, 1'b0, 0);
        applyStimulus(4'd4, 16'h0010, 16'h0000, 1'b0, 2);
        checkOutput("div0 data", resData, 32'h0000_0007);
        checkOutput("div0 err", 32'(resErr), 32'd1);
        checkOutput("div0 acc", accOut, 32'h0000_0007);

        applyStimulus(4'hC, 16'h1111, 16'h2222, 1'b0, 1);
        checkOutput("badop err", {30'd0, resErr, resCarry}, 32'd2);

        // Increment under sustained backpressure
        applyStimulus(4'd10, 16'h7FFF, 16'h0000, 1'b0, 5);
        checkOutput("inc data", resData, 32'h0000_8000);

        // Reset in the middle of EXEC discards the pending result
        cmdOp     = 4'd1;
        cmdA      = 16'h0005;
        cmdB      = 16'h0006;
        cmdUseAcc = 1'b0;
        cmdValid  = 1'b1;
        @(posedge clk); #1;
        cmdValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst acc", accOut, 32'd0);
        checkOutput("midrst res_valid", 32'(resValid), 32'd0);
        checkOutput("midrst alu_func", 32'(aluFunc), 32'd0);
        checkOutput("midrst res_data", resData, 32'd0);
        @(posedge clk); #1;
        rst      = 1'b0;
        modelAcc = 32'd0;
        expData  = 32'd0;
        for (int i = 0; i < SETTLE + 2; i++) begin
            @(posedge clk); #1;
            checkOutput("midrst no valid", 32'(resValid), 32'd0);
        end
        applyStimulus(4'd2, 16'h0001, 16'h0002, 1'b0, 0);
        checkOutput("after rst sub", resData, 32'h0000_FFFF);

        // Random commands, including illegal opcodes and zero divisors
        for (int n = 0; n < 40; n++) begin
            applyStimulus(4'($urandom_range(0, 15)),
                          16'($urandom),
                          ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom),
                          1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
